// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared bus constants for the memory-bus arbiter: master count,
//               owner index width, word address/data widths, active-low
//               strobe levels and read/write encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;
    localparam int WORD_ADDR_W   = 30;
    localparam int WORD_DATA_W   = 32;

    // Active-low strobe levels used on req_/grnt_/as_/rdy_ lines
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } bus_rw_e;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_picker
// Description : Combinational round-robin selector. Rotates the active-high
//               request vector so the slot after the last owner sits at bit 0,
//               priority-encodes the lowest set bit, then rotates the index
//               back. The last owner therefore ends up scanned last.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTER = BUS_MASTER_CH,
    parameter int OWNER_W  = BUS_OWNER_W
) (
    input  logic [N_MASTER-1:0] i_req,
    input  logic [OWNER_W-1:0]  i_last,
    output logic [OWNER_W-1:0]  o_next,
    output logic                o_valid
);

    logic [2*N_MASTER-1:0] w_dbl;
    logic [2*N_MASTER-1:0] w_shift;
    logic [N_MASTER-1:0]   w_rot;
    int                    w_start;
    int                    w_pos;
    int                    w_sum;

    // Rotate, priority-encode lowest requester, rotate the index back
    always_comb begin
        w_start = int'(i_last) + 1;
        if (w_start >= N_MASTER) begin
            w_start = 0;
        end
        w_dbl   = {i_req, i_req};
        w_shift = w_dbl >> w_start;
        w_rot   = w_shift[N_MASTER-1:0];
        w_pos   = 0;
        for (int k = N_MASTER - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = k;
            end
        end
        w_sum = w_start + w_pos;
        if (w_sum >= N_MASTER) begin
            w_sum = w_sum - N_MASTER;
        end
        o_next  = OWNER_W'(w_sum);
        o_valid = |i_req;
    end

endmodule : bus_rr_picker
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter and multiplexer for the shared
//               word-addressed memory bus. One master owns the bus at a time;
//               the owner's address/strobe/rw/data drive the slave and the
//               slave ready is returned to the owner only. The grant is parked
//               on the last owner when nobody requests.
//               Optional macro BUS_ARB_TIMEOUT_EN adds a forced-release
//               counter that takes the bus from an owner that holds it for
//               TIMEOUT_CYCLES while another master waits.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTER       = BUS_MASTER_CH,
    parameter int OWNER_W        = BUS_OWNER_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_MASTER-1:0]             m_req_,
    output logic [N_MASTER-1:0]             m_grnt_,
    input  logic [N_MASTER*WORD_ADDR_W-1:0] m_addr,
    input  logic [N_MASTER-1:0]             m_as_,
    input  logic [N_MASTER-1:0]             m_rw,
    input  logic [N_MASTER*WORD_DATA_W-1:0] m_wr_data,
    output logic [N_MASTER-1:0]             m_rdy_,
    output logic [WORD_ADDR_W-1:0]          s_addr,
    output logic                            s_as_,
    output logic                            s_rw,
    output logic [WORD_DATA_W-1:0]          s_wr_data,
    input  logic                            s_rdy_,
    output logic [OWNER_W-1:0]              owner,
    output logic                            timeout
);

    logic [OWNER_W-1:0]              r_owner;
    logic [N_MASTER-1:0]             w_req;
    logic [N_MASTER-1:0]             w_owner_onehot;
    logic                            w_owner_req;
    logic                            w_others_req;
    logic [OWNER_W-1:0]              w_next;
    logic                            w_valid;
    logic                            w_expire;
    logic [N_MASTER*WORD_ADDR_W-1:0] w_addr_sh;
    logic [N_MASTER*WORD_DATA_W-1:0] w_data_sh;
    logic [N_MASTER-1:0]             w_rdy;

    assign w_req          = ~m_req_;
    assign w_owner_onehot = {{(N_MASTER-1){1'b0}}, 1'b1} << r_owner;
    assign w_owner_req    = w_req[r_owner];
    assign w_others_req   = |(w_req & ~w_owner_onehot);

    bus_rr_picker #(
        .N_MASTER (N_MASTER),
        .OWNER_W  (OWNER_W)
    ) u_picker (
        .i_req    (w_req),
        .i_last   (r_owner),
        .o_next   (w_next),
        .o_valid  (w_valid)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_timeout;

    assign w_expire = w_owner_req && w_others_req && (r_cnt == c_cnt_last);

    // Count cycles the owner holds the bus against waiting masters; pulse on expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_owner_req && w_others_req && !w_expire) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic [15:0] w_unused_cfg;
    assign w_unused_cfg = 16'(TIMEOUT_CYCLES);
    assign w_expire     = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Owner register: hand over when the owner releases (or is forced off)
    // and someone else wants the bus; otherwise stay parked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= '0;
        end else if (w_valid && (!w_owner_req || w_expire)) begin
            r_owner <= w_next;
        end
    end

    assign owner   = r_owner;
    assign m_grnt_ = ~w_owner_onehot;

    // Slave side follows the owner; non-owner strobes never reach the slave
    assign w_addr_sh = m_addr >> (int'(r_owner) * WORD_ADDR_W);
    assign w_data_sh = m_wr_data >> (int'(r_owner) * WORD_DATA_W);
    assign s_addr    = w_addr_sh[WORD_ADDR_W-1:0];
    assign s_wr_data = w_data_sh[WORD_DATA_W-1:0];
    assign s_as_     = m_as_[r_owner];
    assign s_rw      = m_rw[r_owner];

    // Slave ready is returned to the owner only
    always_comb begin
        w_rdy          = {N_MASTER{DISABLE_}};
        w_rdy[r_owner] = s_rdy_;
    end

    assign m_rdy_ = w_rdy;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter: reset values, a table of
//               arbitration vectors, write datapath, forced release / hold,
//               asynchronous reset mid-transfer and a randomized run checked
//               against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int OW = 2;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk;
    logic              reset;
    logic [N-1:0]      m_req_;
    logic [N-1:0]      m_grnt_;
    logic [N*AW-1:0]   m_addr;
    logic [N-1:0]      m_as_;
    logic [N-1:0]      m_rw;
    logic [N*DW-1:0]   m_wr_data;
    logic [N-1:0]      m_rdy_;
    logic [AW-1:0]     s_addr;
    logic              s_as_;
    logic              s_rw;
    logic [DW-1:0]     s_wr_data;
    logic              s_rdy_;
    logic [OW-1:0]     owner;
    logic              timeout;

    int n_vec;
    int n_err;

    // Reference model state
    int   mo;
    int   mcnt;
    logic mto;

    bus_arbiter #(
        .N_MASTER       (N),
        .OWNER_W        (OW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_rdy_    (m_rdy_),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .s_rdy_    (s_rdy_),
        .owner     (owner),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req_n;
        int           exp_owner;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requester after cur, wrapping, with cur itself looked at last
    function automatic int rr_next(input int cur, input logic [N-1:0] rq);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (cur + k) % N;
            if (rq[c]) return c;
        end
        return cur;
    endfunction

    task automatic check_all();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        eg = '1;
        eg[mo] = 1'b0;
        er = '1;
        er[mo] = s_rdy_;
        chk("grant",     64'(m_grnt_),   64'(eg));
        chk("owner",     64'(owner),     64'(mo));
        chk("s_addr",    64'(s_addr),    64'(m_addr[mo*AW +: AW]));
        chk("s_as_",     64'(s_as_),     64'(m_as_[mo]));
        chk("s_rw",      64'(s_rw),      64'(m_rw[mo]));
        chk("s_wr_data", 64'(s_wr_data), 64'(m_wr_data[mo*DW +: DW]));
        chk("m_rdy_",    64'(m_rdy_),    64'(er));
        chk("timeout",   64'(timeout),   64'(mto));
    endtask

    // One clock: model the edge from the inputs now applied, then compare
    task automatic step();
        logic [N-1:0] rq;
        logic [N-1:0] others;
        int   n_mo;
        int   n_cnt;
        logic n_to;
        rq     = ~m_req_;
        others = rq;
        others[mo] = 1'b0;
        n_mo  = mo;
        n_cnt = 0;
        n_to  = 1'b0;
        if (!rq[mo]) begin
            if (rq != '0) n_mo = rr_next(mo, rq);
        end else if (others != '0) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (mcnt == TO - 1) begin
                n_mo = rr_next(mo, rq);
                n_to = 1'b1;
            end else begin
                n_cnt = mcnt + 1;
            end
`endif
        end
        @(posedge clk);
        #1;
        mo   = n_mo;
        mcnt = n_cnt;
        mto  = n_to;
        check_all();
    endtask

    initial begin
        vec_t tbl[15];
        n_vec = 0;
        n_err = 0;

        // Arbitration sequence after reset, owner starts at 0
        tbl[0]  = '{4'b1111, 0};   // nobody requests: parked on 0
        tbl[1]  = '{4'b1111, 0};
        tbl[2]  = '{4'b0101, 1};   // 0 idle, 1 and 3 request: 1 first
        tbl[3]  = '{4'b0101, 1};   // 1 holds
        tbl[4]  = '{4'b0111, 3};   // 1 releases: 3
        tbl[5]  = '{4'b1000, 0};   // 3 releases, 0/1/2 request: wrap to 0
        tbl[6]  = '{4'b1001, 1};
        tbl[7]  = '{4'b1011, 2};
        tbl[8]  = '{4'b1110, 0};   // 2 drops, 0 waiting: 0 wins
        tbl[9]  = '{4'b1010, 0};   // 2 re-raises, 0 holds
        tbl[10] = '{4'b1011, 2};
        tbl[11] = '{4'b1111, 2};   // parked on 2
        tbl[12] = '{4'b1011, 2};   // owner sole requester
        tbl[13] = '{4'b0111, 3};
        tbl[14] = '{4'b1110, 0};   // 3 -> 0 wrap

        m_req_    = '1;
        m_as_     = '1;
        m_rw      = '1;
        s_rdy_    = 1'b1;
        m_addr    = '0;
        m_wr_data = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]    = AW'(32'h100 * (i + 1) + 7);
            m_wr_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
        end
        mo = 0; mcnt = 0; mto = 1'b0;

        // Reset state, observed before any clock edge
        reset = 1'b1;
        #1;
        chk("rst_grant",   64'(m_grnt_), 64'(4'b1110));
        chk("rst_owner",   64'(owner),   64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven arbitration
        for (int i = 0; i < 15; i++) begin
            logic [N-1:0] eg;
            m_req_ = tbl[i].req_n;
            step();
            eg = '1;
            eg[tbl[i].exp_owner] = 1'b0;
            chk($sformatf("tbl%0d_owner", i), 64'(owner),   64'(tbl[i].exp_owner));
            chk($sformatf("tbl%0d_grant", i), 64'(m_grnt_), 64'(eg));
        end

        // Owner 1 write with two ready cycles; other masters strobe too
        m_req_ = 4'b1101;
        step();
        chk("wr_owner", 64'(owner), 64'd1);
        m_addr[1*AW +: AW]    = 30'h0000_0100;
        m_wr_data[1*DW +: DW] = 32'hDEAD_BEEF;
        m_rw   = 4'b1101;
        m_as_  = 4'b0000;
        s_rdy_ = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("wr_s_addr", 64'(s_addr),    64'(30'h0000_0100));
            chk("wr_s_data", 64'(s_wr_data), 64'(32'hDEAD_BEEF));
            chk("wr_s_rw",   64'(s_rw),      64'd0);
            chk("wr_s_as_",  64'(s_as_),     64'd0);
            chk("wr_m_rdy_", 64'(m_rdy_),    64'(4'b1101));
        end
        s_rdy_ = 1'b1;
        m_as_  = '1;
        step();
        chk("wr_m_rdy_idle", 64'(m_rdy_), 64'(4'b1111));

        // Reset while owner 2 is mid-burst, between clock edges
        m_req_ = 4'b1011;
        m_as_  = 4'b1011;
        step();
        chk("burst_owner", 64'(owner), 64'd2);
        step();
        #2;
        reset = 1'b1;
        #1;
        mo = 0; mcnt = 0; mto = 1'b0;
        chk("mid_rst_owner", 64'(owner),   64'd0);
        chk("mid_rst_grant", 64'(m_grnt_), 64'(4'b1110));
        m_req_ = '1;
        m_as_  = '1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all();

        // Owner 0 holds while master 2 waits
        m_req_ = 4'b1010;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            step();
            if (i < TO) begin
                chk("to_hold_owner", 64'(owner), 64'd0);
            end else begin
                chk("to_move_owner", 64'(owner),   64'd2);
                chk("to_pulse",      64'(timeout), 64'd1);
            end
        end
        step();
        chk("to_pulse_end", 64'(timeout), 64'd0);
`else
        for (int i = 0; i < 1000; i++) begin
            step();
            chk("hold_owner",   64'(owner),   64'd0);
            chk("hold_timeout", 64'(timeout), 64'd0);
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < N; m++) begin
                if (m == mo && !m_req_[m])
                    m_req_[m] = ($urandom_range(0, 99) < 85) ? 1'b0 : 1'b1;
                else
                    m_req_[m] = 1'($urandom_range(0, 1));
                m_addr[m*AW +: AW]    = AW'($urandom);
                m_wr_data[m*DW +: DW] = $urandom;
            end
            m_as_  = 4'($urandom);
            m_rw   = 4'($urandom);
            s_rdy_ = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
